// File: rtl/toy_pack.sv
// rtl/toy_pack.sv - shared I-cache MSHR payload types and default sizing
package toy_pack;

  localparam int MSHR_ENTRY_NUM       = 4;
  localparam int TXREQ_CREDIT_MAX_DEF = 4;

  typedef struct packed {
    logic [7:0] set_idx;
    logic [1:0] way;
  } dataram_rd_pld_t;

  typedef struct packed {
    logic [25:0] line_addr;
  } pc_req_t;

endpackage

// File: rtl/icache_mshr_arb_if.sv
// rtl/icache_mshr_arb_if.sv - MSHR entry array <-> arbiter request/grant bundle
interface icache_mshr_arb_if
  import toy_pack::*;
#(
  parameter int N = toy_pack::MSHR_ENTRY_NUM
) ();

  logic [N-1:0]    v_alloc_vld;
  logic            alloc_req;
  logic            alloc_rdy;
  logic [N-1:0]    alloc_oh;

  logic [N-1:0]    v_dataram_rd_vld;
  dataram_rd_pld_t v_dataram_rd_pld [N];
  logic [N-1:0]    v_dataram_rd_rdy;
  logic            dataram_rd_vld;
  logic            dataram_rd_rdy;
  dataram_rd_pld_t dataram_rd_pld;

  logic [N-1:0]    v_txreq_vld;
  pc_req_t         v_txreq_pld [N];
  logic [N-1:0]    v_txreq_rdy;
  logic            txreq_vld;
  logic            txreq_rdy;
  pc_req_t         txreq_pld;

  logic            linefill_done;
  logic            credit_err;

  modport slave (
    input  v_alloc_vld, alloc_req, v_dataram_rd_vld, v_dataram_rd_pld, dataram_rd_rdy,
           v_txreq_vld, v_txreq_pld, txreq_rdy, linefill_done,
    output alloc_rdy, alloc_oh, v_dataram_rd_rdy, dataram_rd_vld, dataram_rd_pld,
           v_txreq_rdy, txreq_vld, txreq_pld, credit_err
  );

  modport master (
    output v_alloc_vld, alloc_req, v_dataram_rd_vld, v_dataram_rd_pld, dataram_rd_rdy,
           v_txreq_vld, v_txreq_pld, txreq_rdy, linefill_done,
    input  alloc_rdy, alloc_oh, v_dataram_rd_rdy, dataram_rd_vld, dataram_rd_pld,
           v_txreq_rdy, txreq_vld, txreq_pld, credit_err
  );

endinterface

// File: rtl/icache_rr_arb_reg.sv
// rtl/icache_rr_arb_reg.sv - round-robin N:1 arbiter feeding a one-entry output register
module icache_rr_arb_reg #(
  parameter int  N = 4,
  parameter type T = logic [7:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_vld_i,
  input  T             req_pld_i [N],
  input  logic         gnt_en_i,
  output logic [N-1:0] req_rdy_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output T             out_pld_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW:0]   NW  = (PW+1)'(N);
  localparam logic [PW-1:0] NM1 = PW'(N - 1);

  logic [PW-1:0] ptr_q, ptr_d, sel;
  logic [PW:0]   sum;
  logic          vld_q, vld_d, found, gnt;
  T              pld_q, pld_d;

  // first requester at or after ptr_q, scanning with wrap
  always_comb begin
    sel   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (sum >= NW) sum = sum - NW;
      if (!found && req_vld_i[sum[PW-1:0]]) begin
        found = 1'b1;
        sel   = sum[PW-1:0];
      end
    end
  end

  assign gnt = found && gnt_en_i && (!vld_q || out_rdy_i);

  always_comb begin
    req_rdy_o = '0;
    ptr_d     = ptr_q;
    vld_d     = vld_q;
    pld_d     = pld_q;
    if (gnt) begin
      req_rdy_o[sel] = 1'b1;
      vld_d          = 1'b1;
      pld_d          = req_pld_i[sel];
      ptr_d          = (sel == NM1) ? '0 : sel + PW'(1);
    end else if (out_rdy_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      vld_q <= 1'b0;
      pld_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      pld_q <= pld_d;
    end
  end

  assign out_vld_o = vld_q;
  assign out_pld_o = pld_q;

endmodule

// File: rtl/icache_mshr_arb.sv
// rtl/icache_mshr_arb.sv - MSHR alloc encoder plus data-RAM/linefill arbiters
// Optional linefill credit throttling: ICACHE_MSHR_TXREQ_CREDIT_EN
module icache_mshr_arb
  import toy_pack::*;
#(
  parameter int MSHR_ENTRY_NUM   = toy_pack::MSHR_ENTRY_NUM,
  parameter int TXREQ_CREDIT_MAX = TXREQ_CREDIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  icache_mshr_arb_if.slave  bus
);

  localparam logic [MSHR_ENTRY_NUM-1:0] ONE = MSHR_ENTRY_NUM'(1);

  logic txreq_gnt_en;

  // isolate lowest set bit: lowest-index free entry
  assign bus.alloc_rdy = |bus.v_alloc_vld;
  assign bus.alloc_oh  = bus.alloc_req ? (bus.v_alloc_vld & ~(bus.v_alloc_vld - ONE)) : '0;

  icache_rr_arb_reg #(.N(MSHR_ENTRY_NUM), .T(dataram_rd_pld_t)) u_dataram_arb (
    .clk       (clk),
    .rst       (rst),
    .req_vld_i (bus.v_dataram_rd_vld),
    .req_pld_i (bus.v_dataram_rd_pld),
    .gnt_en_i  (1'b1),
    .req_rdy_o (bus.v_dataram_rd_rdy),
    .out_vld_o (bus.dataram_rd_vld),
    .out_rdy_i (bus.dataram_rd_rdy),
    .out_pld_o (bus.dataram_rd_pld)
  );

  icache_rr_arb_reg #(.N(MSHR_ENTRY_NUM), .T(pc_req_t)) u_txreq_arb (
    .clk       (clk),
    .rst       (rst),
    .req_vld_i (bus.v_txreq_vld),
    .req_pld_i (bus.v_txreq_pld),
    .gnt_en_i  (txreq_gnt_en),
    .req_rdy_o (bus.v_txreq_rdy),
    .out_vld_o (bus.txreq_vld),
    .out_rdy_i (bus.txreq_rdy),
    .out_pld_o (bus.txreq_pld)
  );

`ifdef ICACHE_MSHR_TXREQ_CREDIT_EN
  localparam int CW = $clog2(TXREQ_CREDIT_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(TXREQ_CREDIT_MAX);

  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;
  logic          txreq_fire;

  assign txreq_fire   = |bus.v_txreq_rdy;
  assign txreq_gnt_en = (credit_q != '0);

  // a return at full credit means the downstream over-acknowledged
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (txreq_fire && !bus.linefill_done) begin
      credit_d = credit_q - CW'(1);
    end else if (!txreq_fire && bus.linefill_done) begin
      if (credit_q == CMAX) err_d = 1'b1;
      else                  credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q <= CMAX;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign bus.credit_err = err_q;
`else
  logic unused_credit;

  assign txreq_gnt_en   = 1'b1;
  assign bus.credit_err = 1'b0;
  assign unused_credit  = bus.linefill_done ^ (TXREQ_CREDIT_MAX > 0);
`endif

endmodule

// File: tb/tb_icache_mshr_arb.sv
// tb/tb_icache_mshr_arb.sv - randomized self-checking bench for icache_mshr_arb
module tb_icache_mshr_arb;
  import toy_pack::*;

  localparam int N    = 4;
  localparam int CMAX = 2;
`ifdef ICACHE_MSHR_TXREQ_CREDIT_EN
  localparam bit CREDIT = 1'b1;
`else
  localparam bit CREDIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_mshr_arb_if #(.N(N)) bus ();

  icache_mshr_arb #(.MSHR_ENTRY_NUM(N), .TXREQ_CREDIT_MAX(CMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          m_ptr [2];
  bit          m_vld [2];
  logic [31:0] m_pld [2];
  int          m_credit;
  bit          m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int ptr, input logic [N-1:0] req, input bit can);
    if (!can) return -1;
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] onehot(input int idx);
    return (idx < 0) ? 64'd0 : (64'd1 << idx);
  endfunction

  task automatic check_outputs();
    logic [9:0]  od;
    logic [25:0] ot;
    od = bus.dataram_rd_pld;
    ot = bus.txreq_pld;
    check("dataram_rd_vld", bus.dataram_rd_vld, m_vld[0]);
    check("dataram_rd_pld", od, m_pld[0]);
    check("txreq_vld", bus.txreq_vld, m_vld[1]);
    check("txreq_pld", ot, m_pld[1]);
    check("credit_err", bus.credit_err, m_err);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.v_alloc_vld = '0; bus.alloc_req = 1'b0;
    bus.v_dataram_rd_vld = '0; bus.dataram_rd_rdy = 1'b0;
    bus.v_txreq_vld = '0; bus.txreq_rdy = 1'b0; bus.linefill_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.v_dataram_rd_pld[i] = '0;
      bus.v_txreq_pld[i] = '0;
    end
    m_ptr[0] = 0; m_ptr[1] = 0; m_vld[0] = 0; m_vld[1] = 0;
    m_pld[0] = 0; m_pld[1] = 0; m_credit = CMAX; m_err = 0;
    #1;
    check_outputs();
    check("rst_v_dataram_rd_rdy", bus.v_dataram_rd_rdy, 0);
    check("rst_v_txreq_rdy", bus.v_txreq_rdy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // one cycle: drive at negedge, check, then advance the model past the next edge
  task automatic step(input logic [N-1:0] av, input bit areq,
                      input logic [N-1:0] dv, input bit drdy,
                      input logic [N-1:0] tv, input bit trdy,
                      input bit done, input bit idp);
    logic [31:0] dp [N];
    logic [31:0] tp [N];
    logic [N-1:0] exp_oh;
    int gd, gt;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      dp[i] = idp ? 32'(i) : 32'($urandom_range(1023));
      tp[i] = idp ? 32'(16 + i) : ($urandom & 32'h03ff_ffff);
      bus.v_dataram_rd_pld[i] = dp[i][9:0];
      bus.v_txreq_pld[i] = tp[i][25:0];
    end
    bus.v_alloc_vld = av; bus.alloc_req = areq;
    bus.v_dataram_rd_vld = dv; bus.dataram_rd_rdy = drdy;
    bus.v_txreq_vld = tv; bus.txreq_rdy = trdy; bus.linefill_done = done;
    #1;
    exp_oh = '0;
    if (areq)
      for (int i = N - 1; i >= 0; i--) if (av[i]) exp_oh = N'(1) << i;
    check("alloc_rdy", bus.alloc_rdy, (av != 0));
    check("alloc_oh", bus.alloc_oh, exp_oh);
    check_outputs();
    gd = pick(m_ptr[0], dv, !m_vld[0] || drdy);
    gt = pick(m_ptr[1], tv, (!m_vld[1] || trdy) && (!CREDIT || m_credit > 0));
    check("v_dataram_rd_rdy", bus.v_dataram_rd_rdy, onehot(gd));
    check("v_txreq_rdy", bus.v_txreq_rdy, onehot(gt));
    if (gd >= 0) begin
      m_vld[0] = 1; m_pld[0] = dp[gd]; m_ptr[0] = (gd + 1) % N;
    end else if (drdy) m_vld[0] = 0;
    if (gt >= 0) begin
      m_vld[1] = 1; m_pld[1] = tp[gt]; m_ptr[1] = (gt + 1) % N;
    end else if (trdy) m_vld[1] = 0;
    if (CREDIT) begin
      if (gt >= 0 && !done) m_credit--;
      else if (gt < 0 && done) begin
        if (m_credit == CMAX) m_err = 1;
        else m_credit++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    do_reset();

    step(4'b1010, 1, '0, 1, '0, 1, 0, 1);
    check("alloc_oh_1010", bus.alloc_oh, 4'b0010);
    step(4'b1010, 0, '0, 1, '0, 1, 0, 1);
    step(4'b0000, 1, '0, 1, '0, 1, 0, 1);

    // entries 0,2,3 with sink always ready
    repeat (6) step('0, 0, 4'b1101, 1, '0, 1, 0, 1);
    // sink stalls with register full, then releases
    repeat (5) step('0, 0, 4'b1101, 0, '0, 1, 0, 1);
    repeat (2) step('0, 0, 4'b1101, 1, '0, 1, 0, 1);

    // drive rr_ptr to 3, then lone entry 3 wraps it to 0
    do_reset();
    step('0, 0, 4'b0100, 1, '0, 1, 0, 1);
    step('0, 0, 4'b1000, 1, '0, 1, 0, 1);
    step('0, 0, 4'b1001, 1, '0, 1, 0, 1);
    check("wrap_to_0", bus.dataram_rd_pld, 10'd3);

    // linefill throttling: four requesters, credit runs out, then returns
    do_reset();
    repeat (4) step('0, 0, '0, 1, 4'b1111, 1, 0, 1);
    step('0, 0, '0, 1, 4'b1111, 1, 1, 1);
    repeat (2) step('0, 0, '0, 1, 4'b1111, 1, 0, 1);
    step('0, 0, '0, 1, 4'b1111, 1, 1, 1);
    repeat (2) step('0, 0, '0, 1, 4'b1111, 1, 0, 1);

    // return at full credit is sticky until reset
    do_reset();
    step('0, 0, '0, 1, '0, 1, 1, 1);
    repeat (3) step('0, 0, '0, 1, '0, 1, 0, 1);
    do_reset();

    for (int it = 0; it < 400; it++) begin
      if (it == 200) do_reset();
      step(N'($urandom), $urandom_range(1), N'($urandom), $urandom_range(3) != 0,
           N'($urandom), $urandom_range(3) != 0, $urandom_range(3) == 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
